legality_check_unit: RTL and testbench

Parametrised, pipelined successor to the combinational illegal-instruction decode check in the Taiga front end. It accepts instructions over a valid/ready handshake and classifies each one as legal or illegal with a cause code. Beyond encoding matching, it adds four checks: runtime extension enables, privilege, CSR read-only and privilege, and RCA-id range. It also keeps a saturating illegal-instruction counter and a sticky first-illegal capture register for trap/tval and debug use.

---
 rtl/legality_check_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_legality_check_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legality_check_unit.sv
// legality_check_unit
// Pipelined legality classifier for instructions entering the front end.
// Each accepted instruction is decoded into per-class match flags. It is then
// checked against the static configuration, the runtime extension enables,
// the privilege it was issued at, the RCA id range and CSR read-only rules.
// The result is a legal/illegal verdict plus a cause code. A saturating
// counter and a sticky first-illegal capture register observe every consumed
// illegal result.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instruction[31:0]        instruction word (valid/ready with
//   instruction_valid/_ready)  instruction_ready)
//   priv[1:0]                privilege of the instruction, captured at acceptance
//   ext_enable[3:0]          runtime enables {RCA, S-mode, A, M}, captured at acceptance
//   flush                    discard every in-flight entry
//   result_valid/_ready      output handshake
//   illegal, cause[2:0]      verdict and cause (0 legal .. 5 CSR read-only write)
//   result_instruction       instruction belonging to the result
//   illegal_count            saturating count of consumed illegal results
//   first_illegal(_valid)    first consumed illegal instruction since clear
//   clear_capture            clear counter and capture register
module legality_check_unit #(
    parameter int PIPE_STAGES   = 2,
    parameter int NUM_RCAS      = 2,
    parameter int COUNT_W       = 16,
    parameter bit USE_MUL       = 1'b1,
    parameter bit USE_DIV       = 1'b1,
    parameter bit USE_AMO       = 1'b1,
    parameter bit USE_RCA       = 1'b1,
    parameter bit ENABLE_M_MODE = 1'b1,
    parameter bit ENABLE_S_MODE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               instruction_valid,
    output logic               instruction_ready,
    input  logic [1:0]         priv,
    input  logic [3:0]         ext_enable,
    input  logic               flush,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               illegal,
    output logic [2:0]         cause,
    output logic [31:0]        result_instruction,
    output logic [COUNT_W-1:0] illegal_count,
    output logic [31:0]        first_illegal,
    output logic               first_illegal_valid,
    input  logic               clear_capture
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_RCA    = 7'b0101011;

    localparam logic [2:0] CAUSE_LEGAL    = 3'd0;
    localparam logic [2:0] CAUSE_UNKNOWN  = 3'd1;
    localparam logic [2:0] CAUSE_EXT_OFF  = 3'd2;
    localparam logic [2:0] CAUSE_PRIV     = 3'd3;
    localparam logic [2:0] CAUSE_RCA_ID   = 3'd4;
    localparam logic [2:0] CAUSE_CSR_RO   = 3'd5;

    localparam logic [2:0] RCA_LIMIT = 3'(NUM_RCAS);

    typedef struct packed {
        logic base;
        logic mul;
        logic div;
        logic amo;
        logic machine;
        logic supervisor;
        logic rca;
        logic csr;
    } class_flags_t;

    typedef struct packed {
        class_flags_t flags;
        logic [11:0]  csr_addr;
        logic [4:0]   rs1;
        logic [2:0]   funct3;
        logic [1:0]   rca_id;
        logic [1:0]   priv;
        logic [3:0]   ext;
        logic [31:0]  instr;
    } decode_t;

    // Pure encoding match; at most one class flag is set for any word.
    function automatic class_flags_t decode_classes(input logic [31:0] ins);
        class_flags_t f;
        logic [6:0]   opcode;
        logic [2:0]   f3;
        logic [6:0]   f7;
        logic [4:0]   f5;
        logic [4:0]   rd;
        logic [4:0]   rs2;
        opcode = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        f5     = ins[31:27];
        rd     = ins[11:7];
        rs2    = ins[24:20];
        f      = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: f.base = 1'b1;
            OPC_JALR:   f.base = (f3 == 3'b000);
            OPC_BRANCH: f.base = (f3 != 3'b010) && (f3 != 3'b011);
            OPC_LOAD:   f.base = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OPC_STORE:  f.base = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
            OPC_OP_IMM: begin
                if (f3 == 3'b001) begin
                    f.base = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    f.base = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end else begin
                    f.base = 1'b1;
                end
            end
            OPC_OP: begin
                case (f7)
                    7'b0000000: f.base = 1'b1;
                    7'b0100000: f.base = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: begin
                        f.mul = ~f3[2];
                        f.div = f3[2];
                    end
                    default:    f.base = 1'b0;
                endcase
            end
            OPC_FENCE: f.base = (f3 == 3'b000) || (f3 == 3'b001);
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if ((ins == 32'h0000_0073) || (ins == 32'h0010_0073)) begin
                        f.base = 1'b1;                       // ECALL / EBREAK
                    end else if (ins == 32'h3020_0073) begin
                        f.machine = 1'b1;                    // MRET
                    end else if ((ins == 32'h1020_0073) || (ins == 32'h1050_0073)) begin
                        f.supervisor = 1'b1;                 // SRET / WFI
                    end else if ((f7 == 7'b0001001) && (rd == 5'd0)) begin
                        f.supervisor = 1'b1;                 // SFENCE.VMA
                    end else begin
                        f = '0;
                    end
                end else if (f3 != 3'b100) begin
                    f.csr = 1'b1;
                end else begin
                    f = '0;
                end
            end
            OPC_AMO: begin
                if (f3 == 3'b010) begin
                    case (f5)
                        5'b00010: f.amo = (rs2 == 5'd0);     // LR.W requires rs2 = 0
                        5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                        5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: f.amo = 1'b1;
                        default: f.amo = 1'b0;
                    endcase
                end else begin
                    f.amo = 1'b0;
                end
            end
            OPC_RCA: f.rca = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    // Capture everything the final stage needs so the input may change freely.
    function automatic decode_t build_decode(input logic [31:0] ins,
                                             input logic [1:0]  p,
                                             input logic [3:0]  ext);
        decode_t d;
        d.flags    = decode_classes(ins);
        d.csr_addr = ins[31:20];
        d.rs1      = ins[19:15];
        d.funct3   = ins[14:12];
        d.rca_id   = ins[13:12];
        d.priv     = p;
        d.ext      = ext;
        d.instr    = ins;
        return d;
    endfunction

    // Priority-ordered verdict: encoding, enables, privilege, RCA range, CSR RO.
    function automatic logic [2:0] classify(input decode_t d);
        logic       no_match;
        logic       static_off;
        logic       ext_off;
        logic       priv_bad;
        logic       rca_bad;
        logic       csr_write;
        logic       ro_write;
        logic [2:0] c;
        no_match   = ~(|d.flags);
        static_off = (d.flags.mul & ~USE_MUL) | (d.flags.div & ~USE_DIV) |
                     (d.flags.amo & ~USE_AMO) | (d.flags.rca & ~USE_RCA) |
                     (d.flags.machine & ~ENABLE_M_MODE) |
                     (d.flags.supervisor & ~ENABLE_S_MODE);
        ext_off    = ((d.flags.mul | d.flags.div) & ~d.ext[0]) |
                     (d.flags.amo & ~d.ext[1]) |
                     (d.flags.supervisor & ~d.ext[2]) |
                     (d.flags.rca & ~d.ext[3]);
        priv_bad   = (d.flags.machine & (d.priv != 2'b11)) |
                     (d.flags.supervisor & (d.priv == 2'b00)) |
                     (d.flags.csr & (d.csr_addr[9:8] > d.priv));
        rca_bad    = d.flags.rca & ({1'b0, d.rca_id} >= RCA_LIMIT);
        // CSRRS/CSRRC forms only write when the source (rs1 or uimm) is non-zero.
        csr_write  = (d.funct3[1:0] == 2'b01) | (d.funct3[1] & (d.rs1 != 5'd0));
        ro_write   = d.flags.csr & (d.csr_addr[11:10] == 2'b11) & csr_write;
        if (no_match | static_off) begin
            c = CAUSE_UNKNOWN;
        end else if (ext_off) begin
            c = CAUSE_EXT_OFF;
        end else if (priv_bad) begin
            c = CAUSE_PRIV;
        end else if (rca_bad) begin
            c = CAUSE_RCA_ID;
        end else if (ro_write) begin
            c = CAUSE_CSR_RO;
        end else begin
            c = CAUSE_LEGAL;
        end
        return c;
    endfunction

    logic               out_ready_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               fin_valid_s;
    decode_t            in_decode_s;
    decode_t            fin_data_s;
    logic [2:0]         fin_cause_s;
    logic               consume_illegal_s;

    logic               result_valid_r;
    logic               illegal_r;
    logic [2:0]         cause_r;
    logic [31:0]        result_instruction_r;
    logic [COUNT_W-1:0] illegal_count_r;
    logic [31:0]        first_illegal_r;
    logic               first_illegal_valid_r;

    assign out_ready_s       = ~result_valid_r | result_ready;
    assign instruction_ready = in_ready_s & ~flush & ~rst;
    assign accept_s          = instruction_valid & instruction_ready;

    // Decode of the word currently presented at the input
    always_comb begin
        in_decode_s = build_decode(instruction, priv, ext_enable);
    end

    generate
        if (PIPE_STAGES >= 2) begin : g_two_stage
            logic    s1_valid_r;
            decode_t s1_data_r;

            assign in_ready_s  = ~s1_valid_r | out_ready_s;
            assign fin_valid_s = s1_valid_r;
            assign fin_data_s  = s1_data_r;

            // Decode stage register: refills whenever it drains or is empty
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid_r <= 1'b0;
                    s1_data_r  <= '0;
                end else if (flush) begin
                    s1_valid_r <= 1'b0;
                end else if (in_ready_s) begin
                    s1_valid_r <= accept_s;
                    if (accept_s) begin
                        s1_data_r <= in_decode_s;
                    end
                end
            end
        end else begin : g_one_stage
            // Decode and combine collapse into the output register.
            assign in_ready_s  = out_ready_s;
            assign fin_valid_s = accept_s;
            assign fin_data_s  = in_decode_s;
        end
    endgenerate

    // Verdict for the entry about to enter the output register
    always_comb begin
        fin_cause_s = classify(fin_data_s);
    end

    // Output register: holds every field stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid_r       <= 1'b0;
            illegal_r            <= 1'b0;
            cause_r              <= CAUSE_LEGAL;
            result_instruction_r <= 32'h0000_0000;
        end else if (flush) begin
            result_valid_r <= 1'b0;
        end else if (out_ready_s) begin
            result_valid_r <= fin_valid_s;
            if (fin_valid_s) begin
                illegal_r            <= (fin_cause_s != CAUSE_LEGAL);
                cause_r              <= fin_cause_s;
                result_instruction_r <= fin_data_s.instr;
            end
        end
    end

    // A consume in the flush cycle still counts: only the handshake matters.
    assign consume_illegal_s = result_valid_r & result_ready & illegal_r;

    // Saturating illegal counter; a coincident consume survives a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count_r <= '0;
        end else if (clear_capture) begin
            illegal_count_r <= consume_illegal_s ? COUNT_W'(1) : '0;
        end else if (consume_illegal_s && (illegal_count_r != {COUNT_W{1'b1}})) begin
            illegal_count_r <= illegal_count_r + COUNT_W'(1);
        end
    end

    // Sticky capture of the first consumed illegal instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            first_illegal_r       <= 32'h0000_0000;
            first_illegal_valid_r <= 1'b0;
        end else if (clear_capture) begin
            first_illegal_valid_r <= consume_illegal_s;
            if (consume_illegal_s) begin
                first_illegal_r <= result_instruction_r;
            end
        end else if (consume_illegal_s && !first_illegal_valid_r) begin
            first_illegal_r       <= result_instruction_r;
            first_illegal_valid_r <= 1'b1;
        end
    end

    assign result_valid        = result_valid_r;
    assign illegal             = illegal_r;
    assign cause               = cause_r;
    assign result_instruction  = result_instruction_r;
    assign illegal_count       = illegal_count_r;
    assign first_illegal       = first_illegal_r;
    assign first_illegal_valid = first_illegal_valid_r;

endmodule

// File: tb/tb_legality_check_unit.sv
// Directed bench with a scoreboard. Two instances are used: a two-stage unit
// with a 16-bit counter, and a one-stage unit with a 4-bit counter for
// saturation. Drivers push expected results into per-instance queues. The
// monitors pop and compare whenever a result is consumed.
module tb_legality_check_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  priv;
    logic [3:0]  ext_enable;
    logic        flush;

    logic [31:0] instruction;
    logic        instruction_valid;
    logic        instruction_ready;
    logic        result_valid;
    logic        result_ready;
    logic        illegal;
    logic [2:0]  cause;
    logic [31:0] result_instruction;
    logic [15:0] illegal_count;
    logic [31:0] first_illegal;
    logic        first_illegal_valid;
    logic        clear_capture;

    logic [31:0] p1_instruction;
    logic        p1_valid;
    logic        p1_ready;
    logic        p1_rvalid;
    logic        p1_rready;
    logic        p1_illegal;
    logic [2:0]  p1_cause;
    logic [31:0] p1_rinstr;
    logic [3:0]  p1_count;
    logic [31:0] p1_first;
    logic        p1_fv;
    logic        p1_clear;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit acc;

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [2:0]  cs;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0_e;
    exp_t m1_e;

    legality_check_unit #(.PIPE_STAGES(2), .NUM_RCAS(2), .COUNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .instruction_ready(instruction_ready), .priv(priv), .ext_enable(ext_enable),
        .flush(flush), .result_valid(result_valid), .result_ready(result_ready),
        .illegal(illegal), .cause(cause), .result_instruction(result_instruction),
        .illegal_count(illegal_count), .first_illegal(first_illegal),
        .first_illegal_valid(first_illegal_valid), .clear_capture(clear_capture)
    );

    legality_check_unit #(.PIPE_STAGES(1), .NUM_RCAS(2), .COUNT_W(4)) u_p1 (
        .clk(clk), .rst(rst),
        .instruction(p1_instruction), .instruction_valid(p1_valid),
        .instruction_ready(p1_ready), .priv(priv), .ext_enable(ext_enable),
        .flush(flush), .result_valid(p1_rvalid), .result_ready(p1_rready),
        .illegal(p1_illegal), .cause(p1_cause), .result_instruction(p1_rinstr),
        .illegal_count(p1_count), .first_illegal(p1_first),
        .first_illegal_valid(p1_fv), .clear_capture(p1_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Present one instruction, retrying up to max_wait cycles; enqueue on acceptance.
    task automatic send(input bit which, input logic [31:0] ins, input bit ill,
                        input logic [2:0] cs, input bit lat, input int max_wait,
                        output bit accepted);
        exp_t e;
        accepted = 1'b0;
        if (which) begin
            p1_instruction = ins;
            p1_valid       = 1'b1;
        end else begin
            instruction       = ins;
            instruction_valid = 1'b1;
        end
        for (int i = 0; i < max_wait && !accepted; i++) begin
            @(negedge clk);
            if ((which ? p1_ready : instruction_ready) == 1'b1) begin
                e.ins = ins;
                e.ill = ill;
                e.cs  = cs;
                e.due = lat ? cyc + (which ? 1 : 2) : -1;
                if (which) q1.push_back(e);
                else       q0.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        p1_valid          = 1'b0;
        instruction_valid = 1'b0;
    endtask

    task automatic put(input bit which, input logic [31:0] ins, input bit ill,
                       input logic [2:0] cs, input bit lat);
        bit a;
        send(which, ins, ill, cs, lat, 20, a);
        chk("accept", 32'(a), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the two-stage instance
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: actual result %h required none", result_instruction);
            end else begin
                m0_e = q0.pop_front();
                chk("main_instr", result_instruction, m0_e.ins);
                chk("main_illegal", 32'(illegal), 32'(m0_e.ill));
                chk("main_cause", 32'(cause), 32'(m0_e.cs));
                if (m0_e.due >= 0) chk("main_latency", 32'(cyc), 32'(m0_e.due));
            end
        end
    end

    // Scoreboard monitor for the one-stage instance
    always @(negedge clk) begin
        if (!rst && p1_rvalid && p1_rready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL p1_unexpected: actual result %h required none", p1_rinstr);
            end else begin
                m1_e = q1.pop_front();
                chk("p1_instr", p1_rinstr, m1_e.ins);
                chk("p1_illegal", 32'(p1_illegal), 32'(m1_e.ill));
                chk("p1_cause", 32'(p1_cause), 32'(m1_e.cs));
                if (m1_e.due >= 0) chk("p1_latency", 32'(cyc), 32'(m1_e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; priv = 2'b11; ext_enable = 4'hF; flush = 1'b0;
        instruction = 32'h0; instruction_valid = 1'b0; result_ready = 1'b1; clear_capture = 1'b0;
        p1_instruction = 32'h0; p1_valid = 1'b0; p1_rready = 1'b1; p1_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_result_instr", result_instruction, 32'h0);
        chk("rst_count", 32'(illegal_count), 32'd0);
        chk("rst_first", first_illegal, 32'h0);
        chk("rst_first_valid", 32'(first_illegal_valid), 32'd0);
        chk("rst_ready", 32'(instruction_ready), 32'd1);
        @(posedge clk);
        #1;

        // Legal stream with exact latency
        put(0, 32'h0000_0033, 1'b0, 3'd0, 1'b1);
        put(0, 32'h0200_0033, 1'b0, 3'd0, 1'b1);
        put(0, 32'h0000_0073, 1'b0, 3'd0, 1'b1);
        drain();
        chk("t1_count", 32'(illegal_count), 32'd0);
        chk("t1_first_valid", 32'(first_illegal_valid), 32'd0);

        // M extension disabled at runtime
        ext_enable = 4'hE;
        put(0, 32'h0200_0033, 1'b1, 3'd2, 1'b1);
        drain();
        chk("t2_count", 32'(illegal_count), 32'd1);
        chk("t2_first", first_illegal, 32'h0200_0033);
        chk("t2_first_valid", 32'(first_illegal_valid), 32'd1);

        clear_capture = 1'b1;
        @(posedge clk);
        #1;
        clear_capture = 1'b0;
        chk("clr_count", 32'(illegal_count), 32'd0);
        chk("clr_first_valid", 32'(first_illegal_valid), 32'd0);

        // Privilege and CSR read-only
        ext_enable = 4'hF;
        priv = 2'b00;
        put(0, 32'h3020_0073, 1'b1, 3'd3, 1'b1);
        priv = 2'b11;
        put(0, 32'hC000_9073, 1'b1, 3'd5, 1'b1);
        drain();
        chk("t3_count", 32'(illegal_count), 32'd2);
        chk("t3_first", first_illegal, 32'h3020_0073);

        // RCA range, unknown encodings and priority corners
        put(0, 32'h0000_202B, 1'b1, 3'd4, 1'b1);
        put(0, 32'h0000_102B, 1'b0, 3'd0, 1'b1);
        put(0, 32'h0000_007F, 1'b1, 3'd1, 1'b1);
        ext_enable = 4'hD;
        put(0, 32'h0000_202F, 1'b1, 3'd2, 1'b1);
        ext_enable = 4'h7;
        put(0, 32'h0000_302B, 1'b1, 3'd2, 1'b1);
        ext_enable = 4'hF;
        priv = 2'b00;
        put(0, 32'h3000_20F3, 1'b1, 3'd3, 1'b1);
        put(0, 32'h1020_0073, 1'b1, 3'd3, 1'b1);
        priv = 2'b01;
        put(0, 32'h1020_0073, 1'b0, 3'd0, 1'b1);
        priv = 2'b11;
        put(0, 32'hC000_2073, 1'b0, 3'd0, 1'b1);
        put(0, 32'h4000_0033, 1'b0, 3'd0, 1'b1);
        put(0, 32'h4000_1033, 1'b1, 3'd1, 1'b1);
        drain();
        chk("t4_count", 32'(illegal_count), 32'd9);
        chk("t4_first", first_illegal, 32'h3020_0073);

        // Backpressure: two entries fill the pipe, third refused
        result_ready = 1'b0;
        put(0, 32'h0000_0033, 1'b0, 3'd0, 1'b0);
        put(0, 32'h0010_0093, 1'b0, 3'd0, 1'b0);
        send(0, 32'h0000_0013, 1'b0, 3'd0, 1'b0, 3, acc);
        chk("stall_third_refused", 32'(acc), 32'd0);
        chk("stall_ready", 32'(instruction_ready), 32'd0);
        chk("stall_valid", 32'(result_valid), 32'd1);
        chk("stall_instr", result_instruction, 32'h0000_0033);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_instr_hold", result_instruction, 32'h0000_0033);
        chk("stall_cause_hold", 32'(cause), 32'd0);
        result_ready = 1'b1;
        put(0, 32'h0000_0013, 1'b0, 3'd0, 1'b0);
        drain();

        // Flush mid-stall, with an instruction offered in the flush cycle
        result_ready = 1'b0;
        put(0, 32'h0000_0033, 1'b0, 3'd0, 1'b0);
        put(0, 32'h0010_0093, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        instruction = 32'h0000_0033;
        instruction_valid = 1'b1;
        #1;
        chk("flush_ready", 32'(instruction_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        instruction_valid = 1'b0;
        q0.delete();
        chk("flush_valid", 32'(result_valid), 32'd0);
        chk("flush_count", 32'(illegal_count), 32'd9);
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_nothing_left", 32'(result_valid), 32'd0);

        // One-stage instance: latency 1, then counter saturation
        put(1, 32'h0000_0033, 1'b0, 3'd0, 1'b1);
        put(1, 32'h3020_0073, 1'b0, 3'd0, 1'b1);
        put(1, 32'h0000_302B, 1'b1, 3'd4, 1'b1);
        for (int i = 0; i < 17; i++) put(1, 32'h0000_007F, 1'b1, 3'd1, 1'b1);
        drain();
        chk("p1_sat_count", 32'(p1_count), 32'd15);
        chk("p1_first", p1_first, 32'h0000_302B);
        chk("p1_first_valid", 32'(p1_fv), 32'd1);

        // Clear coinciding with an illegal consume
        p1_rready = 1'b0;
        put(1, 32'h0000_005B, 1'b1, 3'd1, 1'b0);
        chk("p1_hold_valid", 32'(p1_rvalid), 32'd1);
        p1_rready = 1'b1;
        p1_clear = 1'b1;
        @(posedge clk);
        #1;
        p1_clear = 1'b0;
        chk("p1_clr_count", 32'(p1_count), 32'd1);
        chk("p1_clr_first", p1_first, 32'h0000_005B);
        chk("p1_clr_first_valid", 32'(p1_fv), 32'd1);
        p1_clear = 1'b1;
        @(posedge clk);
        #1;
        p1_clear = 1'b0;
        chk("p1_clr2_count", 32'(p1_count), 32'd0);
        chk("p1_clr2_first_valid", 32'(p1_fv), 32'd0);

        // Reset with entries in flight
        result_ready = 1'b0;
        put(0, 32'h0000_0033, 1'b0, 3'd0, 1'b0);
        put(0, 32'h0010_0093, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        #1;
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_count", 32'(illegal_count), 32'd0);
        chk("mid_rst_first_valid", 32'(first_illegal_valid), 32'd0);
        chk("mid_rst_instr", result_instruction, 32'h0);
        chk("mid_rst_ready", 32'(instruction_ready), 32'd1);
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_empty", 32'(result_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
